digit_serial_adder: RTL and testbench

//  Parametrised multi-cycle adder. Computes s = a + b + cin over WIDTH bits, DIGIT bits per clock.

---
 rtl/digit_serial_adder_pkg.sv | 16 +
 rtl/digit_serial_adder_digit_adder.sv | 28 ++
 rtl/digit_serial_adder.sv | 154 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and
// counter sizing helper.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_e;

    // Counter must stay at least one bit wide when a single digit covers the word.
    function automatic int dsa_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple of full adders; also exposes the carry
// into the top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder, DIGIT bits per clock, valid/ready on both sides.
// Define DSA_OVERFLOW_EN to add the signed-overflow output ovf.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef DSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = dsa_cnt_w(NDIG);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    dsa_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_c;
    logic             dig_cm;
    logic [WIDTH-1:0] s_shift;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_s),
        .cout  (dig_c),
        .c_msb (dig_cm)
    );

    // New digit enters at the MSB; after NDIG steps digit 0 sits at the LSB.
    generate
        if (DIGIT == WIDTH) begin : g_one_step
            assign s_shift = dig_s;
        end else begin : g_multi_step
            assign s_shift = {dig_s, s_q[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef DSA_OVERFLOW_EN
    logic ovf_q, ovf_d;
`else
    logic dsa_unused;
    assign dsa_unused = dig_cm;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef DSA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                s_d     = s_shift;
                carry_d = dig_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    cout_d  = dig_c;
`ifdef DSA_OVERFLOW_EN
                    ovf_d   = dig_cm ^ dig_c;
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef DSA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef DSA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef DSA_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder at 32/4, 8/1 and 8/8; honours DSA_OVERFLOW_EN.
// Results are checked against plain integer arithmetic.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, s;

    logic        n_in_valid, n_cin, n_out_ready;
    logic [7:0]  n_a, n_b;
    logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
    logic [7:0]  s1_s;
    logic        p_in_ready, p_out_valid, p_cout, p_ovf;
    logic [7:0]  p_s;

    int vectors = 0;
    int miscompares = 0;

    digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout)
`ifdef DSA_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(s1_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .out_valid(s1_out_valid),
        .out_ready(n_out_ready), .s(s1_s), .cout(s1_cout)
`ifdef DSA_OVERFLOW_EN
        , .ovf(s1_ovf)
`endif
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(p_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .out_valid(p_out_valid),
        .out_ready(n_out_ready), .s(p_s), .cout(p_cout)
`ifdef DSA_OVERFLOW_EN
        , .ovf(p_ovf)
`endif
    );

`ifndef DSA_OVERFLOW_EN
    assign ovf    = 1'b0;
    assign s1_ovf = 1'b0;
    assign p_ovf  = 1'b0;
`endif

    // {ovf, cout, s} from integer addition; ovf stays 0 when the port is absent.
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic c);
        logic [32:0] t;
        logic        o;
        t = {1'b0, x} + {1'b0, y} + {32'd0, c};
        o = 1'b0;
`ifdef DSA_OVERFLOW_EN
        o = (x[31] == y[31]) && (t[31] != x[31]);
`endif
        return {o, t};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c);
        logic [8:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {8'd0, c};
        o = 1'b0;
`ifdef DSA_OVERFLOW_EN
        o = (x[7] == y[7]) && (t[7] != x[7]);
`endif
        return {o, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the 32-bit DUT; lat counts edges from accept to out_valid.
    task automatic op32(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                        output int lat, output logic [33:0] res);
        in_valid = 1'b1;
        a = oa;
        b = ob;
        cin = oc;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'($urandom_range(0, 1));
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        res = {ovf, cout, s};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        n_in_valid = 1'b0; n_out_ready = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vectors++;
        if ({ovf, cout, s} !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {ovf, cout, s});
        end
        vectors++;
        if ({s1_in_ready, p_in_ready, s1_out_valid, p_out_valid} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_narrow: got %b want 1100",
                     {s1_in_ready, p_in_ready, s1_out_valid, p_out_valid});
        end
    endtask

    task automatic test_carry_wrap();
        int lat;
        logic [33:0] res;
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, res);
        vectors++;
        if (res[31:0] !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL wrap_sum: got %h want 00000000", res[31:0]);
        end
        vectors++;
        if (res[32] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_cout: got %b want 1", res[32]);
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL wrap_latency: got %0d want 8", lat);
        end
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, res);
        vectors++;
        if (res[32:0] !== {1'b1, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL all_ones: got %h want 1ffffffff", res[32:0]);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [33:0] res;
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, res);
        vectors++;
        if (res[32:0] !== {1'b0, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL ovf_sum: got %h want 080000000", res[32:0]);
        end
`ifdef DSA_OVERFLOW_EN
        vectors++;
        if (res[33] !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag: got %b want 1", res[33]);
        end
        op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, res);
        vectors++;
        if (res !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
            miscompares++;
            $display("FAIL ovf_neg: got %h want 37fffffff", res);
        end
`endif
    endtask

    task automatic test_stall();
        int k;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        cin = 1'b1;
        tick();
        a = 32'hDEAD_BEEF;
        b = 32'hCAFE_F00D;
        k = 0;
        while (!out_valid && k < 64) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({out_valid, in_ready, cout, s} !== {1'b1, 1'b0, 1'b0, 32'h2345_678A}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b r=%b c=%b s=%h want v=1 r=0 c=0 s=2345678a",
                         i, out_valid, in_ready, cout, s);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_handoff: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_abort();
        logic seen;
        in_valid = 1'b1;
        a = 32'h0F0F_0F0F;
        b = 32'h1234_4321;
        cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_state: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        end
        vectors++;
        if ({cout, s} !== 33'd0) begin
            miscompares++;
            $display("FAIL abort_sum: got %h want 0", {cout, s});
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | out_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_valid: got %b want 0", seen);
        end
    endtask

    task automatic test_narrow();
        int l1, l8;
        logic [9:0] e;
        for (int n = 0; n < 16; n++) begin
            if (n == 0) begin
                n_a = 8'hAA; n_b = 8'h55; n_cin = 1'b1;
            end else begin
                n_a = 8'($urandom); n_b = 8'($urandom); n_cin = 1'($urandom_range(0, 1));
            end
            e = model8(n_a, n_b, n_cin);
            n_in_valid = 1'b1;
            tick();
            n_in_valid = 1'b0;
            n_a = 8'($urandom);
            n_b = 8'($urandom);
            l1 = -1;
            l8 = -1;
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (s1_out_valid && l1 < 0) l1 = k;
                if (p_out_valid && l8 < 0) l8 = k;
            end
            vectors++;
            if ({s1_ovf, s1_cout, s1_s} !== e) begin
                miscompares++;
                $display("FAIL narrow_d1[%0d]: got %h want %h", n, {s1_ovf, s1_cout, s1_s}, e);
            end
            vectors++;
            if ({p_ovf, p_cout, p_s} !== e) begin
                miscompares++;
                $display("FAIL narrow_d8[%0d]: got %h want %h", n, {p_ovf, p_cout, p_s}, e);
            end
            vectors++;
            if (l1 !== 8 || l8 !== 1) begin
                miscompares++;
                $display("FAIL narrow_latency[%0d]: got %0d/%0d want 8/1", n, l1, l8);
            end
            n_out_ready = 1'b1;
            tick();
            n_out_ready = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_q[$];
        logic [33:0] e, cur, prev_out, got;
        logic        acc, hs, prev_hold;
        int          done, cyc;
        done = 0;
        cyc = 0;
        prev_hold = 1'b0;
        prev_out = '0;
        while (done < 2000 && cyc < 40000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            a = $urandom;
            b = $urandom;
            cin = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            cur = {ovf, cout, s};
            if (prev_hold) begin
                vectors++;
                if (out_valid !== 1'b1 || cur !== prev_out) begin
                    miscompares++;
                    $display("FAIL rand_hold: got v=%b %h want v=1 %h", out_valid, cur, prev_out);
                end
            end
            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            e = model32(a, b, cin);
            if (hs) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious: got %h want no result", cur);
                end else begin
                    got = exp_q.pop_front();
                    if (cur !== got) begin
                        miscompares++;
                        $display("FAIL rand_result[%0d]: got %h want %h", done, cur, got);
                    end
                end
                done++;
            end
            prev_hold = out_valid && !out_ready;
            prev_out = cur;
            tick();
            cyc++;
            if (acc) exp_q.push_back(e);
        end
        vectors++;
        if (done != 2000) begin
            miscompares++;
            $display("FAIL rand_budget: got %0d results want 2000", done);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_stall();
        test_abort();
        test_narrow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
